// File: rtl/memory_access_unit_if.sv
// memory_access_unit_if: EX/MEM request, data-memory handshake and MEM/WB result bundle
interface memory_access_unit_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
);
   logic              mem_read_memory;
   logic              mem_write_memory;
   logic [ADDR_W-1:0] address_memory;
   logic [DATA_W-1:0] store_data_memory;
   logic              dmem_req;
   logic              dmem_we;
   logic [ADDR_W-1:0] dmem_addr;
   logic [DATA_W-1:0] dmem_wdata;
   logic              dmem_ack;
   logic [DATA_W-1:0] dmem_rdata;
   logic [DATA_W-1:0] data_from_memory;
   logic              mem_stall;
   logic              mem_error;
   modport slave (
      input  mem_read_memory, mem_write_memory, address_memory, store_data_memory,
             dmem_ack, dmem_rdata,
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, data_from_memory, mem_stall, mem_error
   );
   modport master (
      output mem_read_memory, mem_write_memory, address_memory, store_data_memory,
             dmem_ack, dmem_rdata,
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, data_from_memory, mem_stall, mem_error
   );
endinterface

// File: rtl/memory_access_unit.sv
// memory_access_unit: MEM-stage data-memory controller, req/ack handshake with timeout and pipeline stall
module memory_access_unit #(
   parameter int DATA_W         = 16,
   parameter int ADDR_W         = 16,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   memory_access_unit_if.slave  bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CYCLES - 1);
   logic [1:0]        r_state;
   logic [CW-1:0]     r_cnt;
   logic              r_req;
   logic              r_we;
   logic              r_err;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic              w_start;
   assign w_start = r_state == S_IDLE && (bus.mem_read_memory || bus.mem_write_memory);
   // stall is combinational in IDLE so the requesting instruction is held the same cycle
   assign bus.mem_stall        = w_start || r_state == S_BUSY;
   assign bus.dmem_req         = r_req;
   assign bus.dmem_we          = r_we;
   assign bus.dmem_addr        = r_addr;
   assign bus.dmem_wdata       = r_wdata;
   assign bus.data_from_memory = r_rdata;
   assign bus.mem_error        = r_err;
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_err   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            S_IDLE: if (w_start) begin
               r_state <= S_BUSY;
               r_cnt   <= '0;
               r_req   <= 1'b1;
               r_we    <= bus.mem_write_memory;
               r_addr  <= bus.address_memory;
               r_wdata <= bus.store_data_memory;
               r_err   <= bus.mem_read_memory && bus.mem_write_memory;
            end
            S_BUSY: if (bus.dmem_ack) begin
               r_state <= S_DONE;
               r_req   <= 1'b0;
               r_rdata <= r_we ? r_rdata : bus.dmem_rdata;
            end else if (r_cnt == C_LAST) begin
               // timeout: abort, flag it and zero a pending load result
               r_state <= S_DONE;
               r_req   <= 1'b0;
               r_err   <= 1'b1;
               r_rdata <= r_we ? r_rdata : '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_memory_access_unit.sv
// tb_memory_access_unit: directed + randomized accesses checked against a per-instruction transaction model
module tb_memory_access_unit;
   localparam int TO = 15;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          total = 0;
   int          bad = 0;
   logic [15:0] exp_data = '0;
   memory_access_unit_if #(.DATA_W(16), .ADDR_W(16)) bus ();
   memory_access_unit #(.DATA_W(16), .ADDR_W(16), .TIMEOUT_CYCLES(TO)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n, input bit force_ack);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.mem_read_memory  = 1'b0;
         bus.mem_write_memory = 1'b0;
         bus.dmem_ack         = force_ack ? 1'b1 : 1'($urandom_range(0, 1));
         bus.dmem_rdata       = 16'($urandom);
         #1;
         chk("idle_req", bus.dmem_req, 0);
         chk("idle_stall", bus.mem_stall, 0);
         chk("idle_err", bus.mem_error, 0);
         chk("idle_data", bus.data_from_memory, exp_data);
      end
   endtask

   // wt = BUSY cycle index carrying the ack; negative or >= TO means no ack (timeout)
   task automatic access(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] wd,
                         input int wt, input logic [15:0] rdv);
      int  stalls;
      int  reqs;
      bit  to;
      bit  done;
      stalls = 0;
      reqs   = 0;
      done   = 0;
      to     = (wt < 0 || wt >= TO);
      @(negedge clk);
      bus.mem_read_memory   = rd;
      bus.mem_write_memory  = wr;
      bus.address_memory    = a;
      bus.store_data_memory = wd;
      bus.dmem_ack          = 1'b0;
      #1;
      chk("start_stall", bus.mem_stall, 1);
      chk("start_req", bus.dmem_req, 0);
      stalls += int'(bus.mem_stall);
      for (int k = 0; k < TO && !done; k++) begin
         @(negedge clk);
         bus.address_memory    = 16'($urandom);
         bus.store_data_memory = 16'($urandom);
         bus.dmem_ack          = (k == wt);
         bus.dmem_rdata        = (k == wt) ? rdv : 16'($urandom);
         #1;
         chk("busy_req", bus.dmem_req, 1);
         chk("busy_we", bus.dmem_we, wr);
         chk("busy_addr", bus.dmem_addr, a);
         chk("busy_wdata", bus.dmem_wdata, wd);
         chk("busy_err", bus.mem_error, (k == 0 && rd && wr));
         chk("busy_data", bus.data_from_memory, exp_data);
         stalls += int'(bus.mem_stall);
         reqs   += int'(bus.dmem_req);
         done = (k == wt);
      end
      @(negedge clk);
      bus.mem_read_memory  = 1'b0;
      bus.mem_write_memory = 1'b0;
      bus.dmem_ack         = 1'($urandom_range(0, 1));
      bus.dmem_rdata       = 16'($urandom);
      if (!wr) exp_data = to ? 16'h0 : rdv;
      #1;
      chk("done_req", bus.dmem_req, 0);
      chk("done_stall", bus.mem_stall, 0);
      chk("done_err", bus.mem_error, to);
      chk("done_data", bus.data_from_memory, exp_data);
      chk("stall_cycles", stalls, to ? TO + 1 : wt + 2);
      chk("req_cycles", reqs, to ? TO : wt + 1);
   endtask

   initial begin
      bus.mem_read_memory   = 1'b0;
      bus.mem_write_memory  = 1'b0;
      bus.address_memory    = '0;
      bus.store_data_memory = '0;
      bus.dmem_ack          = 1'b0;
      bus.dmem_rdata        = '0;
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         #1;
         chk("rst_req", bus.dmem_req, 0);
         chk("rst_we", bus.dmem_we, 0);
         chk("rst_addr", bus.dmem_addr, 0);
         chk("rst_wdata", bus.dmem_wdata, 0);
         chk("rst_data", bus.data_from_memory, 0);
         chk("rst_err", bus.mem_error, 0);
         chk("rst_stall", bus.mem_stall, 0);
      end
      rst = 1'b0;
      idle(3, 1'b0);
      access(1'b1, 1'b0, 16'h0040, 16'h5555, 0, 16'hBEEF);
      access(1'b0, 1'b1, 16'h00A0, 16'h1234, 3, 16'h7777);
      access(1'b1, 1'b0, 16'h0123, 16'h0000, -1, 16'hAAAA);
      idle(2, 1'b1);
      access(1'b1, 1'b0, 16'h0200, 16'h0000, TO - 1, 16'hC0DE);
      // reset in the second BUSY cycle, then a stray ack in IDLE
      @(negedge clk);
      bus.mem_read_memory  = 1'b1;
      bus.mem_write_memory = 1'b0;
      bus.address_memory   = 16'h0300;
      bus.dmem_ack         = 1'b0;
      #1;
      chk("r5_stall", bus.mem_stall, 1);
      @(negedge clk);
      #1;
      chk("r5_busy1", bus.dmem_req, 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("r5_busy2", bus.dmem_req, 1);
      @(negedge clk);
      rst                  = 1'b0;
      bus.mem_read_memory  = 1'b0;
      bus.dmem_ack         = 1'b1;
      bus.dmem_rdata       = 16'hDEAD;
      exp_data             = 16'h0;
      #1;
      chk("r5_req", bus.dmem_req, 0);
      chk("r5_stall0", bus.mem_stall, 0);
      chk("r5_data", bus.data_from_memory, 0);
      idle(2, 1'b0);
      access(1'b1, 1'b0, 16'h0010, 16'h0000, 1, 16'h1111);
      access(1'b0, 1'b1, 16'h0011, 16'h2222, 0, 16'h3333);
      access(1'b1, 1'b1, 16'h0012, 16'h4444, 2, 16'h5555);
      for (int n = 0; n < 25; n++) begin
         int r;
         int w;
         r = $urandom_range(0, 5);
         w = ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(0, 6);
         access(r <= 2 || r == 5, r >= 3, 16'($urandom), 16'($urandom), w, 16'($urandom));
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3), 1'b0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
